// File: rtl/dp_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_job_arbiter_if
// Brief    : Requester/engine bundle for the dot-product job arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dp_job_arbiter_if #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 5,
   parameter int MEM3_ADDR_WIDTH = 4
);
   logic [NUM_REQ-1:0]                 req;
   logic [NUM_REQ*ADDR_WIDTH-1:0]      req_src_addr;
   logic [NUM_REQ*MEM3_ADDR_WIDTH-1:0] req_dst_addr;
   logic                               eng_done;
   logic [NUM_REQ-1:0]                 grant;
   logic [NUM_REQ-1:0]                 job_done;
   logic                               job_err;
   logic                               eng_start;
   logic [ADDR_WIDTH-1:0]              eng_src_addr;
   logic [MEM3_ADDR_WIDTH-1:0]         eng_dst_addr;
   logic                               busy;
   logic [7:0]                         jobs_completed;

   // Requesters and the engine together form the master side.
   modport master (
      output req, req_src_addr, req_dst_addr, eng_done,
      input  grant, job_done, job_err, eng_start, eng_src_addr, eng_dst_addr,
             busy, jobs_completed
   );

   modport slave (
      input  req, req_src_addr, req_dst_addr, eng_done,
      output grant, job_done, job_err, eng_start, eng_src_addr, eng_dst_addr,
             busy, jobs_completed
   );
endinterface
`default_nettype wire

// File: rtl/dp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_job_arbiter
// Brief    : Round-robin arbiter sharing one dot-product engine among
//            NUM_REQ requesters, with per-job timeout and job counter.
// Revision : 1.0 - initial release
// ============================================================================
module dp_job_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 5,
   parameter int MEM3_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   dp_job_arbiter_if.slave bus
);

   localparam int                IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0]    c_num_req      = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0]  c_last_idx     = IDX_W'(NUM_REQ - 1);
   localparam logic [7:0]        c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT     = 2'd2,
      S_COMPLETE = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [IDX_W-1:0]           r_rr_ptr;
   logic [IDX_W-1:0]           r_owner;
   logic [7:0]                 r_wait_cnt;
   logic                       r_err;
   logic [NUM_REQ-1:0]         r_grant;
   logic [ADDR_WIDTH-1:0]      r_src;
   logic [MEM3_ADDR_WIDTH-1:0] r_dst;
   logic [7:0]                 r_jobs;

   logic [ADDR_WIDTH-1:0]      w_src_arr [NUM_REQ];
   logic [MEM3_ADDR_WIDTH-1:0] w_dst_arr [NUM_REQ];
   logic [IDX_W:0]             w_cand;
   logic [IDX_W-1:0]           w_win;
   logic                       w_found;
   logic [NUM_REQ-1:0]         w_win_oh;
   logic                       w_timeout;
   logic [IDX_W-1:0]           w_rr_nxt;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_src_arr[gi] = bus.req_src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_dst_arr[gi] = bus.req_dst_addr[gi*MEM3_ADDR_WIDTH +: MEM3_ADDR_WIDTH];
      end
   endgenerate

   // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first hit wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (w_cand >= c_num_req) begin
            w_cand = w_cand - c_num_req;
         end
         if (!w_found && bus.req[w_cand[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      w_win_oh        = '0;
      w_win_oh[w_win] = w_found;
   end

   assign w_timeout = (r_wait_cnt == c_timeout_last);
   assign w_rr_nxt  = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_found) w_state_nxt = S_ISSUE;
         S_ISSUE:    w_state_nxt = S_WAIT;
         S_WAIT:     if (bus.eng_done || w_timeout) w_state_nxt = S_COMPLETE;
         S_COMPLETE: w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Job context: captured at arbitration, held until the job is retired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
         r_grant    <= '0;
         r_src      <= '0;
         r_dst      <= '0;
         r_jobs     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_win_oh;
                  r_owner <= w_win;
                  r_src   <= w_src_arr[w_win];
                  r_dst   <= w_dst_arr[w_win];
               end
            end
            S_ISSUE: begin
               r_wait_cnt <= '0;
               r_err      <= 1'b0;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
               // A completion arriving on the timeout cycle still counts as success.
               if (!bus.eng_done && w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            S_COMPLETE: begin
               r_grant  <= '0;
               r_rr_ptr <= w_rr_nxt;
               if (!r_err) begin
                  r_jobs <= r_jobs + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.grant          = r_grant;
   assign bus.job_done       = (r_state == S_COMPLETE) ? r_grant : '0;
   assign bus.job_err        = (r_state == S_COMPLETE) && r_err;
   assign bus.eng_start      = (r_state == S_ISSUE);
   assign bus.eng_src_addr   = r_src;
   assign bus.eng_dst_addr   = r_dst;
   assign bus.busy           = (r_state != S_IDLE);
   assign bus.jobs_completed = r_jobs;

endmodule
`default_nettype wire

// File: tb/tb_dp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_job_arbiter
// Brief    : Scoreboard bench for dp_job_arbiter (default and short timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_job_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int MW = 4;

   typedef struct {
      logic [N-1:0]  done;
      logic          err;
      logic [AW-1:0] src;
      logic [MW-1:0] dst;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n_a;
   logic rst_n_b;
   int   n_vec = 0;
   int   n_err = 0;
   int   lat_a = 0;
   int   lat_b = 0;
   int   cnt_a = 0;
   int   cnt_b = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   dp_job_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MEM3_ADDR_WIDTH(MW)) ifa ();
   dp_job_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MEM3_ADDR_WIDTH(MW)) ifb ();

   dp_job_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MEM3_ADDR_WIDTH(MW), .TIMEOUT_CYCLES(255))
      u_dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa.slave));

   dp_job_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MEM3_ADDR_WIDTH(MW), .TIMEOUT_CYCLES(8))
      u_dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb.slave));

   always #5 clk = ~clk;

   // Engine models: eng_done pulses lat cycles after eng_start; lat=0 never answers.
   always @(negedge clk or negedge rst_n_a) begin
      if (!rst_n_a) begin
         cnt_a        = 0;
         ifa.eng_done = 1'b0;
      end else begin
         ifa.eng_done = 1'b0;
         if (ifa.eng_start) begin
            cnt_a = lat_a;
         end else if (cnt_a > 0) begin
            cnt_a = cnt_a - 1;
            if (cnt_a == 0) ifa.eng_done = 1'b1;
         end
      end
   end

   always @(negedge clk or negedge rst_n_b) begin
      if (!rst_n_b) begin
         cnt_b        = 0;
         ifb.eng_done = 1'b0;
      end else begin
         ifb.eng_done = 1'b0;
         if (ifb.eng_start) begin
            cnt_b = lat_b;
         end else if (cnt_b > 0) begin
            cnt_b = cnt_b - 1;
            if (cnt_b == 0) ifb.eng_done = 1'b1;
         end
      end
   end

   task automatic wait_job_a(input int budget, output int cyc, output int n_start, output bit oh_bad);
      cyc = -1; n_start = 0; oh_bad = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (ifa.eng_start) n_start++;
         if (!$onehot0(ifa.grant)) oh_bad = 1'b1;
         if (ifa.job_done != '0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic wait_job_b(input int budget, output int cyc, output int n_start, output bit oh_bad);
      cyc = -1; n_start = 0; oh_bad = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (ifb.eng_start) n_start++;
         if (!$onehot0(ifb.grant)) oh_bad = 1'b1;
         if (ifb.job_done != '0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [27:0] va;
      logic [27:0] vb;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      ifa.req = '0; ifa.req_src_addr = '0; ifa.req_dst_addr = '0;
      ifb.req = '0; ifb.req_src_addr = '0; ifb.req_dst_addr = '0;
      repeat (3) @(negedge clk);
      va = {ifa.grant, ifa.job_done, ifa.job_err, ifa.eng_start, ifa.eng_src_addr,
            ifa.eng_dst_addr, ifa.busy, ifa.jobs_completed};
      vb = {ifb.grant, ifb.job_done, ifb.job_err, ifb.eng_start, ifb.eng_src_addr,
            ifb.eng_dst_addr, ifb.busy, ifb.jobs_completed};
      n_vec++;
      if (va !== 28'h0) begin n_err++; $display("FAIL reset_a: outputs=%h expected 0", va); end
      n_vec++;
      if (vb !== 28'h0) begin n_err++; $display("FAIL reset_b: outputs=%h expected 0", vb); end
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({ifa.busy, ifa.grant, ifa.eng_start} !== 6'b0) begin
         n_err++; $display("FAIL idle_no_req: busy/grant/start=%b expected 0", {ifa.busy, ifa.grant, ifa.eng_start});
      end
   endtask

   task automatic test_single_job();
      exp_t e; int cyc; int ns; bit ohb;
      lat_a = 10;
      ifa.req_src_addr[4:0] = 5'd3;
      ifa.req_dst_addr[3:0] = 4'd7;
      ifa.req = 4'b0001;
      sb_a.push_back(exp_t'{4'b0001, 1'b0, 5'd3, 4'd7});
      @(negedge clk);
      n_vec++;
      if ({ifa.grant, ifa.eng_start, ifa.eng_src_addr, ifa.eng_dst_addr} !== {4'b0001, 1'b1, 5'd3, 4'd7}) begin
         n_err++; $display("FAIL single_issue: grant=%b start=%b src=%0d dst=%0d expected 0001/1/3/7",
                           ifa.grant, ifa.eng_start, ifa.eng_src_addr, ifa.eng_dst_addr);
      end
      ifa.req = '0;
      ifa.req_src_addr[4:0] = 5'd9;
      ifa.req_dst_addr[3:0] = 4'd1;
      wait_job_a(40, cyc, ns, ohb);
      n_vec++;
      if (cyc !== 11) begin n_err++; $display("FAIL single_latency: job_done after %0d cycles expected 11", cyc); end
      n_vec++;
      if (ns !== 0 || ohb) begin n_err++; $display("FAIL single_start: extra starts=%0d onehot_bad=%0d expected 0/0", ns, ohb); end
      n_vec++;
      if (sb_a.size() == 0) begin n_err++; $display("FAIL single_sb: queue empty"); end
      else begin
         e = sb_a.pop_front();
         if ({ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
            n_err++; $display("FAIL single_done: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d",
                              ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr, e.done, e.err, e.src, e.dst);
         end
      end
      @(negedge clk);
      n_vec++;
      if ({ifa.jobs_completed, ifa.busy, ifa.grant} !== {8'd1, 1'b0, 4'b0000}) begin
         n_err++; $display("FAIL single_after: jobs=%0d busy=%b grant=%b expected 1/0/0000",
                           ifa.jobs_completed, ifa.busy, ifa.grant);
      end
   endtask

   task automatic test_round_robin();
      exp_t e; int cyc; int ns; bit ohb;
      rst_n_a = 1'b0;
      @(negedge clk);
      lat_a = 3;
      for (int i = 0; i < N; i++) begin
         ifa.req_src_addr[i*AW +: AW] = AW'(8 + i);
         ifa.req_dst_addr[i*MW +: MW] = MW'(1 + i);
      end
      ifa.req = 4'b1111;
      rst_n_a = 1'b1;
      for (int j = 0; j < 5; j++) begin
         sb_a.push_back(exp_t'{4'(1 << (j % 4)), 1'b0, 5'(8 + j % 4), 4'(1 + j % 4)});
      end
      for (int j = 0; j < 5; j++) begin
         wait_job_a(30, cyc, ns, ohb);
         n_vec++;
         if (cyc < 0 || ns !== 1 || ohb) begin
            n_err++; $display("FAIL rr_job%0d: cycles=%0d starts=%0d onehot_bad=%0d expected done/1/0", j, cyc, ns, ohb);
         end
         n_vec++;
         if (sb_a.size() == 0) begin n_err++; $display("FAIL rr_sb%0d: queue empty", j); end
         else begin
            e = sb_a.pop_front();
            if ({ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
               n_err++; $display("FAIL rr_done%0d: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d", j,
                                 ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr, e.done, e.err, e.src, e.dst);
            end
         end
      end
      ifa.req = '0;
      @(negedge clk);
      n_vec++;
      if ({ifa.jobs_completed, ifa.busy} !== {8'd5, 1'b0}) begin
         n_err++; $display("FAIL rr_count: jobs=%0d busy=%b expected 5/0", ifa.jobs_completed, ifa.busy);
      end
   endtask

   task automatic test_timeout();
      exp_t e; int cyc; int ns; bit ohb;
      lat_b = 0;
      ifb.req_src_addr[14:10] = 5'd21;
      ifb.req_dst_addr[11:8]  = 4'd12;
      ifb.req = 4'b0100;
      sb_b.push_back(exp_t'{4'b0100, 1'b1, 5'd21, 4'd12});
      @(negedge clk);
      n_vec++;
      if ({ifb.grant, ifb.eng_start} !== 5'b01001) begin
         n_err++; $display("FAIL to_issue: grant=%b start=%b expected 0100/1", ifb.grant, ifb.eng_start);
      end
      ifb.req = '0;
      wait_job_b(30, cyc, ns, ohb);
      n_vec++;
      if (cyc !== 9) begin n_err++; $display("FAIL to_latency: job_done %0d cycles after issue expected 9", cyc); end
      n_vec++;
      if (sb_b.size() == 0) begin n_err++; $display("FAIL to_sb: queue empty"); end
      else begin
         e = sb_b.pop_front();
         if ({ifb.job_done, ifb.job_err, ifb.eng_src_addr, ifb.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
            n_err++; $display("FAIL to_done: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d",
                              ifb.job_done, ifb.job_err, ifb.eng_src_addr, ifb.eng_dst_addr, e.done, e.err, e.src, e.dst);
         end
      end
      @(negedge clk);
      n_vec++;
      if ({ifb.jobs_completed, ifb.busy, ifb.job_err} !== {8'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL to_count: jobs=%0d busy=%b err=%b expected 0/0/0", ifb.jobs_completed, ifb.busy, ifb.job_err);
      end
   endtask

   task automatic test_tie();
      exp_t e; int cyc; int ns; bit ohb;
      lat_b = 8;
      ifb.req_src_addr[4:0] = 5'd30;
      ifb.req_dst_addr[3:0] = 4'd5;
      ifb.req = 4'b0001;
      sb_b.push_back(exp_t'{4'b0001, 1'b0, 5'd30, 4'd5});
      @(negedge clk);
      ifb.req = '0;
      wait_job_b(30, cyc, ns, ohb);
      n_vec++;
      if (cyc !== 9) begin n_err++; $display("FAIL tie_latency: job_done %0d cycles after issue expected 9", cyc); end
      n_vec++;
      if (sb_b.size() == 0) begin n_err++; $display("FAIL tie_sb: queue empty"); end
      else begin
         e = sb_b.pop_front();
         if ({ifb.job_done, ifb.job_err, ifb.eng_src_addr, ifb.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
            n_err++; $display("FAIL tie_done: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d",
                              ifb.job_done, ifb.job_err, ifb.eng_src_addr, ifb.eng_dst_addr, e.done, e.err, e.src, e.dst);
         end
      end
      @(negedge clk);
      n_vec++;
      if (ifb.jobs_completed !== 8'd1) begin
         n_err++; $display("FAIL tie_count: jobs=%0d expected 1", ifb.jobs_completed);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e; int cyc; int ns; bit ohb; int seen;
      logic [27:0] va;
      lat_a = 0;
      ifa.req = 4'b0001;
      @(negedge clk);
      repeat (3) @(negedge clk);
      n_vec++;
      if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL mr_busy: busy=%b expected 1", ifa.busy); end
      rst_n_a = 1'b0;
      #1;
      va = {ifa.grant, ifa.job_done, ifa.job_err, ifa.eng_start, ifa.eng_src_addr,
            ifa.eng_dst_addr, ifa.busy, ifa.jobs_completed};
      n_vec++;
      if (va !== 28'h0) begin n_err++; $display("FAIL mr_async: outputs=%h expected 0", va); end
      ifa.req = 4'b1010;
      ifa.req_src_addr[9:5] = 5'd17;
      ifa.req_dst_addr[7:4] = 4'd9;
      lat_a = 2;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (ifa.job_done != '0) seen++;
      end
      n_vec++;
      if (seen !== 0) begin n_err++; $display("FAIL mr_no_done: job_done seen %0d times expected 0", seen); end
      rst_n_a = 1'b1;
      sb_a.push_back(exp_t'{4'b0010, 1'b0, 5'd17, 4'd9});
      @(negedge clk);
      n_vec++;
      if ({ifa.grant, ifa.eng_start} !== 5'b00101) begin
         n_err++; $display("FAIL mr_grant: grant=%b start=%b expected 0010/1", ifa.grant, ifa.eng_start);
      end
      ifa.req = '0;
      wait_job_a(20, cyc, ns, ohb);
      n_vec++;
      if (cyc !== 3) begin n_err++; $display("FAIL mr_latency: job_done after %0d cycles expected 3", cyc); end
      n_vec++;
      if (sb_a.size() == 0) begin n_err++; $display("FAIL mr_sb: queue empty"); end
      else begin
         e = sb_a.pop_front();
         if ({ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
            n_err++; $display("FAIL mr_done: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d",
                              ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr, e.done, e.err, e.src, e.dst);
         end
      end
      @(negedge clk);
      n_vec++;
      if (ifa.jobs_completed !== 8'd1) begin n_err++; $display("FAIL mr_count: jobs=%0d expected 1", ifa.jobs_completed); end
   endtask

   task automatic test_wrap();
      exp_t e; int cyc; int ns; bit ohb;
      rst_n_a = 1'b0;
      @(negedge clk);
      lat_a = 1;
      ifa.req_src_addr = '0; ifa.req_dst_addr = '0;
      ifa.req_src_addr[4:0] = 5'd2; ifa.req_src_addr[9:5] = 5'd4;
      ifa.req_dst_addr[3:0] = 4'd3; ifa.req_dst_addr[7:4] = 4'd6;
      ifa.req = 4'b0011;
      rst_n_a = 1'b1;
      for (int j = 0; j < 256; j++) begin
         sb_a.push_back((j % 2 == 0) ? exp_t'{4'b0001, 1'b0, 5'd2, 4'd3} : exp_t'{4'b0010, 1'b0, 5'd4, 4'd6});
      end
      for (int j = 0; j < 256; j++) begin
         wait_job_a(20, cyc, ns, ohb);
         n_vec++;
         if (cyc < 0 || sb_a.size() == 0) begin
            n_err++; $display("FAIL wrap_job%0d: cycles=%0d queue=%0d expected done/nonempty", j, cyc, sb_a.size());
         end else begin
            e = sb_a.pop_front();
            if ({ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr} !== {e.done, e.err, e.src, e.dst}) begin
               n_err++; $display("FAIL wrap_done%0d: done=%b err=%b src=%0d dst=%0d expected %b/%b/%0d/%0d", j,
                                 ifa.job_done, ifa.job_err, ifa.eng_src_addr, ifa.eng_dst_addr, e.done, e.err, e.src, e.dst);
            end
         end
         if (j == 255) begin
            n_vec++;
            if (ifa.jobs_completed !== 8'd255) begin
               n_err++; $display("FAIL wrap_pre: jobs=%0d expected 255", ifa.jobs_completed);
            end
         end
      end
      ifa.req = '0;
      @(negedge clk);
      n_vec++;
      if ({ifa.jobs_completed, ifa.busy} !== {8'd0, 1'b0}) begin
         n_err++; $display("FAIL wrap_count: jobs=%0d busy=%b expected 0/0", ifa.jobs_completed, ifa.busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_round_robin();
      test_timeout();
      test_tie();
      test_mid_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d miscompares=%0d", n_vec, n_err);
      $fatal(1);
   end

endmodule
`default_nettype wire
